// File: rtl/fetch_unit.sv
// fetch_unit: PC register + IF/ID stage, one outstanding imem request, states REQ/HOLD/DROP.
// 1 cycle imem_valid->IF/ID; a stalled response parks in HOLD; FETCH_PERF_EN adds stall/redirect counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IF_IDWrite,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] redirect_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        stall;

  assign stall = !PCWrite || !IF_IDWrite;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (branch_taken) begin
      pc_d         = branch_target;
      ifid_valid_d = 1'b0;
      buf_d        = 32'h0;
      case (state_q)
        S_REQ:   state_d = imem_valid ? S_REQ : S_DROP;
        S_HOLD:  state_d = S_REQ;
        default: state_d = S_DROP;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_valid) begin
            if (stall) begin
              buf_d   = imem_rdata;
              state_d = S_HOLD;
            end else begin
              ifid_pc_d    = pc_q;
              ifid_instr_d = imem_rdata;
              ifid_valid_d = 1'b1;
              pc_d         = pc_q + 32'd4;
            end
          end else if (!stall) begin
            ifid_valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = buf_q;
            ifid_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
            state_d      = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_valid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
    // DROP keeps presenting the stale address until its response drains.
    addr_d = (state_d == S_DROP) ? addr_q : pc_d;
    req_d  = (state_d != S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b1;
      buf_q        <= 32'h0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= 32'h0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      buf_q        <= buf_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign IF_ID_pc    = ifid_pc_q;
  assign IF_ID_instr = ifid_instr_q;
  assign IF_ID_valid = ifid_valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    if (branch_taken && redirect_cnt_q != 32'hFFFF_FFFF) redirect_cnt_d = redirect_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q    <= 32'h0;
      redirect_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit; expected values hand-computed with rdata = addr ^ 32'hA5A5_A5A5.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, PCWrite, IF_IDWrite, branch_taken, imem_valid;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, IF_ID_valid;
  logic [31:0] imem_addr, IF_ID_pc, IF_ID_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt, redirect_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .IF_ID_pc(IF_ID_pc), .IF_ID_instr(IF_ID_instr), .IF_ID_valid(IF_ID_valid)
`ifdef FETCH_PERF_EN
    , .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
`endif
  );

  typedef struct {
    logic        rst, pcw, ifw, bt;
    logic [31:0] tgt;
    logic        iv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr, e_pc, e_instr;
    logic        e_vld;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic pcw, input logic ifw, input logic bt,
                     input logic [31:0] tgt, input logic iv, input logic [31:0] rd,
                     input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_pc,
                     input logic [31:0] e_instr, input logic e_vld);
    vec_t v;
    v.rst = r; v.pcw = pcw; v.ifw = ifw; v.bt = bt; v.tgt = tgt; v.iv = iv; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_instr = e_instr; v.e_vld = e_vld;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  // Drive inputs, take one rising edge, settle 1 time unit past it.
  task automatic step(input logic r, input logic pcw, input logic ifw, input logic bt,
                      input logic [31:0] tgt, input logic iv, input logic [31:0] rd);
    rst = r; PCWrite = pcw; IF_IDWrite = ifw; branch_taken = bt;
    branch_target = tgt; imem_valid = iv; imem_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input int idx, input logic e_req, input logic [31:0] e_addr,
                         input logic [31:0] e_pc, input logic [31:0] e_instr, input logic e_vld);
    chk("imem_req", idx, {31'b0, imem_req}, {31'b0, e_req});
    chk("imem_addr", idx, imem_addr, e_addr);
    chk("IF_ID_pc", idx, IF_ID_pc, e_pc);
    chk("IF_ID_instr", idx, IF_ID_instr, e_instr);
    chk("IF_ID_valid", idx, {31'b0, IF_ID_valid}, {31'b0, e_vld});
  endtask

  initial begin
    rst = 1'b1; PCWrite = 1'b1; IF_IDWrite = 1'b1; branch_taken = 1'b0;
    branch_target = 32'h0; imem_valid = 1'b0; imem_rdata = 32'h0;

    //   rst pcw ifw bt target        iv rdata          req addr          IF_pc         IF_instr      vld
    add(1, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0,         32'h0,        32'h0,        0);
    add(0, 1, 1, 0, 32'h0,         1, 32'hA5A5A5A5,  1, 32'h4,         32'h0,        32'hA5A5A5A5, 1);
    add(0, 1, 1, 0, 32'h0,         1, 32'hA5A5A5A1,  1, 32'h8,         32'h4,        32'hA5A5A5A1, 1);
    add(0, 1, 1, 0, 32'h0,         1, 32'hA5A5A5AD,  1, 32'hC,         32'h8,        32'hA5A5A5AD, 1);
    add(0, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'hC,         32'h8,        32'hA5A5A5AD, 0);
    // response while stalled is parked in HOLD; a stray valid in HOLD is ignored
    add(0, 0, 0, 0, 32'h0,         1, 32'hA5A5A5A9,  0, 32'hC,         32'h8,        32'hA5A5A5AD, 0);
    add(0, 0, 0, 0, 32'h0,         1, 32'hDEADBEEF,  0, 32'hC,         32'h8,        32'hA5A5A5AD, 0);
    add(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'hC,         32'h8,        32'hA5A5A5AD, 0);
    add(0, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h10,        32'hC,        32'hA5A5A5A9, 1);
    // redirect with request outstanding -> DROP, late response discarded
    add(0, 1, 1, 1, 32'h100,       0, 32'h0,         1, 32'h10,        32'hC,        32'hA5A5A5A9, 0);
    add(0, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h10,        32'hC,        32'hA5A5A5A9, 0);
    add(0, 1, 1, 0, 32'h0,         1, 32'hA5A5A5B5,  1, 32'h100,       32'hC,        32'hA5A5A5A9, 0);
    add(0, 1, 1, 0, 32'h0,         1, 32'hA5A5A4A5,  1, 32'h104,       32'h100,      32'hA5A5A4A5, 1);
    // redirect + valid + stall in the same cycle
    add(0, 0, 1, 1, 32'h200,       1, 32'hA5A5A4A1,  1, 32'h200,       32'h100,      32'hA5A5A4A5, 0);
    add(0, 1, 1, 0, 32'h0,         1, 32'hA5A5A7A5,  1, 32'h204,       32'h200,      32'hA5A5A7A5, 1);
    // reset from HOLD, with a response arriving during reset
    add(0, 1, 0, 0, 32'h0,         1, 32'hA5A5A7A1,  0, 32'h204,       32'h200,      32'hA5A5A7A5, 1);
    add(1, 1, 1, 0, 32'h0,         1, 32'h12345678,  1, 32'h0,         32'h0,        32'h0,        0);
    add(0, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0,         32'h0,        32'h0,        0);
    add(0, 1, 1, 0, 32'h0,         1, 32'hA5A5A5A5,  1, 32'h4,         32'h0,        32'hA5A5A5A5, 1);
    // redirect out of HOLD (still stalled) discards the buffer
    add(0, 0, 1, 0, 32'h0,         1, 32'hA5A5A5A1,  0, 32'h4,         32'h0,        32'hA5A5A5A5, 1);
    add(0, 0, 1, 1, 32'h300,       0, 32'h0,         1, 32'h300,       32'h0,        32'hA5A5A5A5, 0);
    add(0, 1, 1, 0, 32'h0,         1, 32'hA5A5A6A5,  1, 32'h304,       32'h300,      32'hA5A5A6A5, 1);
    // redirect in DROP moves pc only; old address stays on the bus
    add(0, 1, 1, 1, 32'hFFFFFFFC,  0, 32'h0,         1, 32'h304,       32'h300,      32'hA5A5A6A5, 0);
    add(0, 1, 1, 1, 32'h400,       0, 32'h0,         1, 32'h304,       32'h300,      32'hA5A5A6A5, 0);
    add(0, 1, 1, 0, 32'h0,         1, 32'hA5A5A6A1,  1, 32'h400,       32'h300,      32'hA5A5A6A5, 0);
    // pc wraps modulo 2^32
    add(0, 1, 1, 1, 32'hFFFFFFFC,  1, 32'hA5A5A1A5,  1, 32'hFFFFFFFC,  32'h300,      32'hA5A5A6A5, 0);
    add(0, 1, 1, 0, 32'h0,         1, 32'h5A5A5A59,  1, 32'h0,         32'hFFFFFFFC, 32'h5A5A5A59, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].pcw, vecs[i].ifw, vecs[i].bt, vecs[i].tgt, vecs[i].iv, vecs[i].rd);
      chk_all(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_vld);
    end

    // REQ with no response: stall holds a valid IF/ID, release inserts a bubble
    step(0, 1, 0, 0, 32'h0, 0, 32'h0);
    chk_all(100, 1, 32'h0, 32'hFFFFFFFC, 32'h5A5A5A59, 1);
    step(0, 1, 1, 0, 32'h0, 0, 32'h0);
    chk_all(101, 1, 32'h0, 32'hFFFFFFFC, 32'h5A5A5A59, 0);

`ifdef FETCH_PERF_EN
    step(1, 1, 1, 0, 32'h0, 0, 32'h0);
    chk("stall_cnt_rst", 200, stall_cnt, 32'd0);
    chk("redirect_cnt_rst", 200, redirect_cnt, 32'd0);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 32'h0, 0, 32'h0);
    step(0, 1, 1, 1, 32'h40, 0, 32'h0);
    step(0, 1, 1, 0, 32'h0, 0, 32'h0);
    step(0, 1, 1, 1, 32'h80, 0, 32'h0);
    step(0, 1, 1, 0, 32'h0, 0, 32'h0);
    chk("stall_cnt", 201, stall_cnt, 32'd5);
    chk("redirect_cnt", 201, redirect_cnt, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 PCWrite  input  1  hazard-unit PC enable; 0 = stall.
REQ-005 IF_IDWrite  input  1  hazard-unit IF/ID enable; 0 = stall.
REQ-006 branch_taken  input  1  redirect request from EX; one-cycle pulse.
REQ-007 branch_target  input  32  redirect PC, sampled when branch_taken=1.
REQ-008 imem_valid  input  1  instruction memory response valid.
REQ-009 imem_rdata  input  32  instruction word, valid when imem_valid=1.
REQ-010 imem_req  output  1  fetch request to instruction memory.
REQ-011 imem_addr  output  32  fetch address, registered.
REQ-012 IF_ID_pc  output  32  PC of instruction held in IF/ID.
REQ-013 IF_ID_instr  output  32  instruction held in IF/ID.
REQ-014 IF_ID_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.

Function
REQ-015 stall SHALL be defined as (PCWrite==0 || IF_IDWrite==0).
REQ-016 Memory protocol SHALL allow one outstanding request; imem_req and imem_addr stay stable from assertion until the cycle imem_valid=1.
REQ-017 imem_valid SHALL be ignored whenever no request is outstanding.
REQ-018 States SHALL be REQ, HOLD, DROP.
REQ-019 REQ: imem_req=1, imem_addr=pc. On imem_valid with no stall and no redirect, IF/ID loads {pc, imem_rdata, valid=1} and pc advances to pc+4 (mod 2^32); state stays REQ. The next request's imem_addr is pc+4 in the following cycle.
REQ-020 REQ, imem_valid with stall: imem_rdata SHALL be captured into a 32-bit hold buffer; IF/ID and pc hold; next state HOLD.
REQ-021 REQ, no imem_valid: IF/ID loads a bubble (valid=0) if not stalled and holds if stalled.
REQ-022 HOLD: imem_req=0. On the first cycle with no stall, IF/ID loads {pc, buffer, valid=1}, pc advances to pc+4, next state REQ.
REQ-023 Redirect (branch_taken=1) SHALL take priority over stall and normal fetch in every state: pc <= branch_target, IF_ID_valid <= 0, hold buffer discarded.
REQ-024 Redirect in REQ with imem_valid=0 SHALL go to DROP; with imem_valid=1 the response SHALL be discarded and next state is REQ.
REQ-025 Redirect in HOLD or DROP SHALL go to REQ or DROP respectively. A redirect in DROP updates pc only.
REQ-026 DROP: imem_req=1 with the old imem_addr held. The returning response SHALL be discarded, then next state is REQ with imem_addr=pc.
REQ-027 Latency SHALL be one cycle from imem_valid to IF_ID_valid in REQ with no stall.
REQ-028 IF_ID_valid SHALL never be 1 for an instruction fetched from an address older than the last redirect.

Reset
REQ-029 On rst=1 at a clock edge, the following SHALL apply regardless of state or outstanding request: pc=RESET_PC, state=REQ, IF_ID_pc=0, IF_ID_instr=0, IF_ID_valid=0, hold buffer=0.
REQ-030 In the first cycle after reset, imem_req=1 and imem_addr=RESET_PC.
REQ-031 A response arriving in the cycle reset is applied SHALL be discarded.

Configuration
REQ-032 Macro FETCH_PERF_EN defined: add output stall_cnt (32 bits), which counts cycles with stall=1, and output redirect_cnt (32 bits), which counts branch_taken pulses. Both are reset to 0 and saturate at 32'hFFFF_FFFF.
REQ-033 Macro FETCH_PERF_EN undefined: these ports and counters are absent. All other behaviour is identical.

Verification
REQ-034 Reset, then imem_valid every cycle after the request, with rdata=addr^32'hA5A5_A5A5 -> IF_ID_pc sequence 0, 4, 8 with matching instr and IF_ID_valid=1.
REQ-035 imem_valid with PCWrite=IF_IDWrite=0 for 3 cycles -> state HOLD, imem_req=0, IF/ID unchanged; on release, the buffered word appears with IF_ID_pc=pc and pc advances by 4.
REQ-036 branch_taken with target 32'h0000_0100 while a request is outstanding -> DROP, and the late response is discarded (IF_ID_valid=0); the next imem_addr is 32'h100.
REQ-037 branch_taken in the same cycle as imem_valid and stall=1 -> response discarded, IF_ID_valid=0, next imem_addr=target.
REQ-038 rst asserted in HOLD -> all outputs at reset values the next cycle, and imem_addr=RESET_PC.
REQ-039 With FETCH_PERF_EN defined, 5 stall cycles and 2 branch_taken pulses -> stall_cnt=5, redirect_cnt=2.
